// File: rtl/cpu_pkg.sv
// Shared datapath types: operand width and ALU status flags.
// Imported by the ALU, register file and controller.
package cpu_pkg;

  localparam int BW = 16;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } flags_t;

endpackage

// File: rtl/rf_flag_reg.sv
// Status flag register with sticky overflow.
// RF_BYPASS_EN: flags_out follows flags_in while flags_en is high.
module rf_flag_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flags_en,
  input  logic [2:0] flags_in,
  input  logic       ovf_clr,
  output logic [2:0] flags_out,
  output logic       ovf_sticky
);

  flags_t flags_q;
  logic   sticky_q;

  // Latch ALU flags; sticky set dominates a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (flags_en)
        flags_q <= flags_t'(flags_in);
      sticky_q <= (sticky_q & ~ovf_clr)
                | (flags_en & flags_in[FLAG_OVF]);
    end
  end

`ifdef RF_BYPASS_EN
  // Forward incoming flags in the cycle they are latched
  always_comb begin
    flags_out = flags_q;
    if (flags_en)
      flags_out = flags_in;
  end
`else
  // Registered flags only
  always_comb begin
    flags_out = flags_q;
  end
`endif

  assign ovf_sticky = sticky_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file, R0 hardwired to zero, 2R/1W.
// RF_BYPASS_EN: same-cycle write-through to the read ports.
module reg_file
  import cpu_pkg::*;
#(
  parameter  int BW     = cpu_pkg::BW,
  parameter  int N_REGS = 8,
  localparam int AW     = $clog2(N_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data,
  input  logic          flags_en,
  input  logic [2:0]    flags_in,
  input  logic          ovf_clr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [BW-1:0] rd_data_a,
  output logic [BW-1:0] rd_data_b,
  output logic [2:0]    flags_out,
  output logic          ovf_sticky
);

  logic [BW-1:0] mem [N_REGS];
  logic          wr_ok;

  assign wr_ok = wr_en && (wr_addr != '0);

  // Storage; writes to R0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port A mux
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != '0)
      rd_data_a = mem[rd_addr_a];
`ifdef RF_BYPASS_EN
    if (wr_ok && rd_addr_a == wr_addr)
      rd_data_a = wr_data;
`endif
  end

  // Read port B mux
  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != '0)
      rd_data_b = mem[rd_addr_b];
`ifdef RF_BYPASS_EN
    if (wr_ok && rd_addr_b == wr_addr)
      rd_data_b = wr_data;
`endif
  end

  rf_flag_reg u_flags (
    .clk       (clk),
    .rst_n     (rst_n),
    .flags_en  (flags_en),
    .flags_in  (flags_in),
    .ovf_clr   (ovf_clr),
    .flags_out (flags_out),
    .ovf_sticky(ovf_sticky)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file.
// Honours RF_BYPASS_EN to select expected hazard behaviour.
module tb_reg_file;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        flags_en;
  logic [2:0]  flags_in;
  logic        ovf_clr;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [2:0]  flags_out;
  logic        ovf_sticky;

  reg_file #(.BW(16), .N_REGS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_en  (flags_en),
    .flags_in  (flags_in),
    .ovf_clr   (ovf_clr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .flags_out (flags_out),
    .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
    logic        s;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m [8];
  logic [2:0]  mf;
  logic        ms;
  int          checks;
  int          errors;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(
    input logic [2:0] a, input logic we,
    input logic [2:0] wa, input logic [15:0] wd);
    if (a == 3'd0)
      return 16'h0;
    if (BYP && we && wa != 3'd0 && a == wa)
      return wd;
    return m[a];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
    mf = 3'b000;
    ms = 1'b0;
  endtask

  task automatic idle(input logic [2:0] ra,
                      input logic [2:0] rb);
    wr_en = 0; wr_addr = 0; wr_data = 0;
    flags_en = 0; flags_in = 0; ovf_clr = 0;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
  endtask

  // Entered just after a negedge; returns at the next negedge.
  task automatic drive(input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic fe,
                       input logic [2:0] fi, input logic oc,
                       input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    flags_en = fe; flags_in = fi; ovf_clr = oc;
    rd_addr_a = ra; rd_addr_b = rb;
    e.a = exp_rd(ra, we, wa, wd);
    e.b = exp_rd(rb, we, wa, wd);
    e.f = (BYP && fe) ? fi : mf;
    e.s = ms;
    q.push_back(e);
    #1;
    e = q.pop_front();
    chk("rd_a", 32'(rd_data_a), 32'(e.a));
    chk("rd_b", 32'(rd_data_b), 32'(e.b));
    chk("flags", 32'(flags_out), 32'(e.f));
    chk("sticky", 32'(ovf_sticky), 32'(e.s));
    @(posedge clk);
    if (we && wa != 3'd0) m[wa] = wd;
    ms = (ms & ~oc) | (fe & fi[2]);
    if (fe) mf = fi;
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mreset();
    rst_n = 1'b0;
    idle(3'd3, 3'd5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rd_a", 32'(rd_data_a), 32'h0);
    chk("rst_flags", 32'(flags_out), 32'h0);
    chk("rst_sticky", 32'(ovf_sticky), 32'h0);
    rst_n = 1'b1;

    drive(1, 3, 16'h7FFF, 0, 0, 0, 3, 5);
    drive(1, 5, 16'h8000, 0, 0, 0, 3, 5);
    idle(3, 5);
    chk("r3", 32'(rd_data_a), 32'h7FFF);
    chk("r5", 32'(rd_data_b), 32'h8000);
    idle(5, 5);
    chk("r5_a", 32'(rd_data_a), 32'h8000);
    chk("r5_b", 32'(rd_data_b), 32'h8000);

    drive(1, 0, 16'hBEEF, 0, 0, 0, 0, 0);
    idle(0, 0);
    chk("r0_a", 32'(rd_data_a), 32'h0);
    chk("r0_b", 32'(rd_data_b), 32'h0);

    drive(1, 2, 16'h0001, 0, 0, 0, 2, 0);
    wr_en = 1; wr_addr = 2; wr_data = 16'h1234;
    rd_addr_a = 2;
    #1;
    chk("hazard", 32'(rd_data_a), BYP ? 32'h1234 : 32'h0001);
    drive(1, 2, 16'h1234, 0, 0, 0, 2, 2);
    idle(2, 0);
    chk("hazard_after", 32'(rd_data_a), 32'h1234);

    drive(0, 0, 0, 1, 3'b100, 0, 0, 0);
    idle(0, 0);
    chk("f_ovf", 32'(flags_out), 32'b100);
    chk("s_set", 32'(ovf_sticky), 32'h1);
    drive(0, 0, 0, 1, 3'b001, 0, 0, 0);
    idle(0, 0);
    chk("f_zero", 32'(flags_out), 32'b001);
    chk("s_hold", 32'(ovf_sticky), 32'h1);
    drive(0, 0, 0, 1, 3'b100, 1, 0, 0);
    idle(0, 0);
    chk("s_setwins", 32'(ovf_sticky), 32'h1);
    drive(0, 0, 0, 0, 3'b000, 1, 0, 0);
    idle(0, 0);
    chk("s_clr", 32'(ovf_sticky), 32'h0);

    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            16'($urandom),
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
    end

    drive(1, 3, 16'h5A5A, 1, 3'b110, 0, 3, 5);
    idle(3, 3);
    rst_n = 1'b0;
    #1;
    mreset();
    chk("arst_rd_a", 32'(rd_data_a), 32'h0);
    chk("arst_rd_b", 32'(rd_data_b), 32'h0);
    chk("arst_flags", 32'(flags_out), 32'h0);
    chk("arst_sticky", 32'(ovf_sticky), 32'h0);
    wr_en = 1; wr_addr = 3; wr_data = 16'hFFFF;
    rd_addr_a = 5;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 0);
    chk("rst_write_lost", 32'(rd_data_a), 32'h0);
    drive(1, 4, 16'hCAFE, 0, 0, 0, 4, 3);
    idle(4, 3);
    chk("post_rst_wr", 32'(rd_data_a), 32'hCAFE);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
